// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: per-thread scalar and vector register files feeding a registered operand output.
// Optional macro OF_WRITE_BYPASS_EN forwards a same-cycle write into the operands read in that cycle.
module operand_fetch_stage #(
  parameter int NUM_VECTOR_LANES = 16,
  parameter int THREADS_PER_CORE = 4,
  localparam int THREAD_IDX_W = (THREADS_PER_CORE > 1) ? $clog2(THREADS_PER_CORE) : 1,
  localparam int SUBCYCLE_W = 4,
  localparam int INSTR_W = 69,
  localparam int VECTOR_W = NUM_VECTOR_LANES * 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        ts_instruction_valid,
  input  logic [INSTR_W-1:0]          ts_instruction,
  input  logic [THREAD_IDX_W-1:0]     ts_thread_idx,
  input  logic [SUBCYCLE_W-1:0]       ts_subcycle,
  input  logic                        wb_rollback_en,
  input  logic [THREAD_IDX_W-1:0]     wb_rollback_thread_idx,
  input  logic                        wb_writeback_en,
  input  logic [THREAD_IDX_W-1:0]     wb_writeback_thread_idx,
  input  logic                        wb_writeback_is_vector,
  input  logic [4:0]                  wb_writeback_reg,
  input  logic [VECTOR_W-1:0]         wb_writeback_value,
  input  logic [NUM_VECTOR_LANES-1:0] wb_writeback_mask,
  output logic                        of_instruction_valid,
  output logic [INSTR_W-1:0]          of_instruction,
  output logic [THREAD_IDX_W-1:0]     of_thread_idx,
  output logic [SUBCYCLE_W-1:0]       of_subcycle,
  output logic [VECTOR_W-1:0]         of_operand1,
  output logic [VECTOR_W-1:0]         of_operand2,
  output logic [NUM_VECTOR_LANES-1:0] of_mask_value
);

  typedef logic [NUM_VECTOR_LANES-1:0][31:0] vector_t;
  typedef logic [THREAD_IDX_W+4:0] rf_addr_t;

  // Field order is the packed layout of the instruction bus, MSB first.
  typedef struct packed {
    logic [5:0]  alu_op;
    logic        has_dest;
    logic        dest_is_vector;
    logic [4:0]  dest_reg;
    logic        is_masked;
    logic        has_vector1;
    logic [4:0]  vector_sel1;
    logic [4:0]  scalar_sel1;
    logic        has_vector2;
    logic [4:0]  vector_sel2;
    logic        has_scalar2;
    logic [4:0]  scalar_sel2;
    logic [31:0] immediate_value;
  } decoded_instruction_t;

  localparam int RF_DEPTH = (1 << THREAD_IDX_W) * 32;

  logic [31:0] scalar_rf_r [RF_DEPTH];
  vector_t     vector_rf_r [RF_DEPTH];

  decoded_instruction_t ts_instr_s;
  vector_t              wb_value_s;
  rf_addr_t             write_addr_s;
  rf_addr_t             scalar1_addr_s;
  rf_addr_t             scalar2_addr_s;
  rf_addr_t             vector1_addr_s;
  rf_addr_t             vector2_addr_s;
  logic [31:0]          scalar1_s;
  logic [31:0]          scalar2_s;
  vector_t              vector1_s;
  vector_t              vector2_s;
  vector_t              operand1_s;
  vector_t              operand2_s;
  logic [NUM_VECTOR_LANES-1:0] mask_s;
  logic                 valid_s;

  logic                        of_valid_r;
  decoded_instruction_t        of_instr_r;
  logic [THREAD_IDX_W-1:0]     of_thread_r;
  logic [SUBCYCLE_W-1:0]       of_subcycle_r;
  vector_t                     of_operand1_r;
  vector_t                     of_operand2_r;
  logic [NUM_VECTOR_LANES-1:0] of_mask_r;

  assign ts_instr_s     = ts_instruction;
  assign wb_value_s     = wb_writeback_value;
  assign write_addr_s   = {wb_writeback_thread_idx, wb_writeback_reg};
  assign scalar1_addr_s = {ts_thread_idx, ts_instr_s.scalar_sel1};
  assign scalar2_addr_s = {ts_thread_idx, ts_instr_s.scalar_sel2};
  assign vector1_addr_s = {ts_thread_idx, ts_instr_s.vector_sel1};
  assign vector2_addr_s = {ts_thread_idx, ts_instr_s.vector_sel2};

`ifdef OF_WRITE_BYPASS_EN
  function automatic vector_t merge_lanes(input vector_t old_value, input vector_t new_value,
                                          input logic [NUM_VECTOR_LANES-1:0] lane_mask);
    vector_t merged;
    for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
      merged[lane] = lane_mask[lane] ? new_value[lane] : old_value[lane];
    end
    return merged;
  endfunction

  logic scalar_wr_s;
  logic vector_wr_s;
  assign scalar_wr_s = wb_writeback_en && !wb_writeback_is_vector;
  assign vector_wr_s = wb_writeback_en && wb_writeback_is_vector;

  // Forwarded reads: a matching write this cycle overrides the stored value.
  assign scalar1_s = (scalar_wr_s && (write_addr_s == scalar1_addr_s)) ? wb_value_s[0]
                                                                       : scalar_rf_r[scalar1_addr_s];
  assign scalar2_s = (scalar_wr_s && (write_addr_s == scalar2_addr_s)) ? wb_value_s[0]
                                                                       : scalar_rf_r[scalar2_addr_s];
  assign vector1_s = (vector_wr_s && (write_addr_s == vector1_addr_s))
                   ? merge_lanes(vector_rf_r[vector1_addr_s], wb_value_s, wb_writeback_mask)
                   : vector_rf_r[vector1_addr_s];
  assign vector2_s = (vector_wr_s && (write_addr_s == vector2_addr_s))
                   ? merge_lanes(vector_rf_r[vector2_addr_s], wb_value_s, wb_writeback_mask)
                   : vector_rf_r[vector2_addr_s];
`else
  assign scalar1_s = scalar_rf_r[scalar1_addr_s];
  assign scalar2_s = scalar_rf_r[scalar2_addr_s];
  assign vector1_s = vector_rf_r[vector1_addr_s];
  assign vector2_s = vector_rf_r[vector2_addr_s];
`endif

  // Operand selection; mask comes from the low lanes of scalar_sel2 (lane count assumed <= 32).
  always_comb begin
    operand1_s = '0;
    operand2_s = '0;
    mask_s     = {NUM_VECTOR_LANES{1'b1}};
    if (ts_instr_s.has_vector1) begin
      operand1_s = vector1_s;
    end else begin
      operand1_s = {NUM_VECTOR_LANES{scalar1_s}};
    end
    if (ts_instr_s.has_vector2) begin
      operand2_s = vector2_s;
    end else if (ts_instr_s.has_scalar2) begin
      operand2_s = {NUM_VECTOR_LANES{scalar2_s}};
    end else begin
      operand2_s = {NUM_VECTOR_LANES{ts_instr_s.immediate_value}};
    end
    if (ts_instr_s.is_masked) begin
      mask_s = scalar2_s[NUM_VECTOR_LANES-1:0];
    end else begin
      mask_s = {NUM_VECTOR_LANES{1'b1}};
    end
  end

  assign valid_s = ts_instruction_valid
                && !(wb_rollback_en && (wb_rollback_thread_idx == ts_thread_idx));

  // Register file write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wb_writeback_en) begin
      if (wb_writeback_is_vector) begin
        for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
          if (wb_writeback_mask[lane]) begin
            vector_rf_r[write_addr_s][lane] <= wb_value_s[lane];
          end
        end
      end else begin
        scalar_rf_r[write_addr_s] <= wb_value_s[0];
      end
    end
  end

  // Output pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      of_valid_r    <= 1'b0;
      of_instr_r    <= '0;
      of_thread_r   <= '0;
      of_subcycle_r <= '0;
      of_operand1_r <= '0;
      of_operand2_r <= '0;
      of_mask_r     <= '0;
    end else begin
      of_valid_r    <= valid_s;
      of_instr_r    <= ts_instr_s;
      of_thread_r   <= ts_thread_idx;
      of_subcycle_r <= ts_subcycle;
      of_operand1_r <= operand1_s;
      of_operand2_r <= operand2_s;
      of_mask_r     <= mask_s;
    end
  end

  assign of_instruction_valid = of_valid_r;
  assign of_instruction       = of_instr_r;
  assign of_thread_idx        = of_thread_r;
  assign of_subcycle          = of_subcycle_r;
  assign of_operand1          = of_operand1_r;
  assign of_operand2          = of_operand2_r;
  assign of_mask_value        = of_mask_r;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic against an array-based model.
// Expectations follow OF_WRITE_BYPASS_EN when it is defined for the build.
module tb_operand_fetch_stage;
  localparam int L  = 16;
  localparam int T  = 4;
  localparam int VW = L * 32;

  typedef logic [L-1:0][31:0] vec_t;
  typedef struct packed {
    logic [5:0]  alu_op;
    logic        has_dest;
    logic        dest_is_vector;
    logic [4:0]  dest_reg;
    logic        is_masked;
    logic        has_vector1;
    logic [4:0]  vector_sel1;
    logic [4:0]  scalar_sel1;
    logic        has_vector2;
    logic [4:0]  vector_sel2;
    logic        has_scalar2;
    logic [4:0]  scalar_sel2;
    logic [31:0] immediate_value;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  logic ts_valid;
  instr_t ts_instr;
  logic [1:0] ts_thread;
  logic [3:0] ts_sub;
  logic rb_en;
  logic [1:0] rb_t;
  logic wb_en;
  logic [1:0] wb_t;
  logic wb_vec;
  logic [4:0] wb_reg;
  vec_t wb_val;
  logic [L-1:0] wb_mask;

  logic of_valid;
  instr_t of_instr;
  logic [1:0] of_thread;
  logic [3:0] of_sub;
  vec_t of_op1;
  vec_t of_op2;
  logic [L-1:0] of_mask;

  operand_fetch_stage #(.NUM_VECTOR_LANES(L), .THREADS_PER_CORE(T)) dut (
    .clk(clk), .reset(reset),
    .ts_instruction_valid(ts_valid), .ts_instruction(ts_instr),
    .ts_thread_idx(ts_thread), .ts_subcycle(ts_sub),
    .wb_rollback_en(rb_en), .wb_rollback_thread_idx(rb_t),
    .wb_writeback_en(wb_en), .wb_writeback_thread_idx(wb_t),
    .wb_writeback_is_vector(wb_vec), .wb_writeback_reg(wb_reg),
    .wb_writeback_value(wb_val), .wb_writeback_mask(wb_mask),
    .of_instruction_valid(of_valid), .of_instruction(of_instr),
    .of_thread_idx(of_thread), .of_subcycle(of_sub),
    .of_operand1(of_op1), .of_operand2(of_op2), .of_mask_value(of_mask)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] s_m [T][32];
  vec_t        v_m [T][32];

  logic e_all;
  logic e_valid;
  instr_t e_instr;
  logic [1:0] e_thread;
  logic [3:0] e_sub;
  vec_t e_op1;
  vec_t e_op2;
  logic [L-1:0] e_mask;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t bcast(input logic [31:0] x);
    vec_t v;
    for (int i = 0; i < L; i++) v[i] = x;
    return v;
  endfunction

  function automatic logic [31:0] rd_s(input int t, input int r);
    logic [31:0] v;
    v = s_m[t][r];
`ifdef OF_WRITE_BYPASS_EN
    if (wb_en && !wb_vec && int'(wb_t) == t && int'(wb_reg) == r) v = wb_val[0];
`endif
    return v;
  endfunction

  function automatic vec_t rd_v(input int t, input int r);
    vec_t v;
    v = v_m[t][r];
`ifdef OF_WRITE_BYPASS_EN
    if (wb_en && wb_vec && int'(wb_t) == t && int'(wb_reg) == r)
      for (int i = 0; i < L; i++) if (wb_mask[i]) v[i] = wb_val[i];
`endif
    return v;
  endfunction

  task automatic predict();
    logic [31:0] m;
    int t;
    t = int'(ts_thread);
    if (reset) begin
      e_all = 1'b1; e_valid = 1'b0; e_instr = '0; e_thread = '0; e_sub = '0;
      e_op1 = '0; e_op2 = '0; e_mask = '0;
    end else begin
      e_all    = 1'b0;
      e_valid  = ts_valid && !(rb_en && rb_t == ts_thread);
      e_instr  = ts_instr;
      e_thread = ts_thread;
      e_sub    = ts_sub;
      e_op1 = ts_instr.has_vector1 ? rd_v(t, int'(ts_instr.vector_sel1))
                                   : bcast(rd_s(t, int'(ts_instr.scalar_sel1)));
      if (ts_instr.has_vector2) e_op2 = rd_v(t, int'(ts_instr.vector_sel2));
      else if (ts_instr.has_scalar2) e_op2 = bcast(rd_s(t, int'(ts_instr.scalar_sel2)));
      else e_op2 = bcast(ts_instr.immediate_value);
      m = rd_s(t, int'(ts_instr.scalar_sel2));
      e_mask = ts_instr.is_masked ? m[L-1:0] : {L{1'b1}};
    end
  endtask

  task automatic commit();
    if (wb_en) begin
      if (wb_vec) begin
        for (int i = 0; i < L; i++) if (wb_mask[i]) v_m[wb_t][wb_reg][i] = wb_val[i];
      end else begin
        s_m[wb_t][wb_reg] = wb_val[0];
      end
    end
  endtask

  task automatic cycle();
    predict();
    commit();
    @(posedge clk);
    #1;
    check("valid", VW'(of_valid), VW'(e_valid));
    if (e_valid || e_all) begin
      check("instr", VW'(of_instr), VW'(e_instr));
      check("thread", VW'(of_thread), VW'(e_thread));
      check("subcycle", VW'(of_sub), VW'(e_sub));
      check("operand1", of_op1, e_op1);
      check("operand2", of_op2, e_op2);
      check("mask", VW'(of_mask), VW'(e_mask));
    end
  endtask

  task automatic idle();
    reset = 1'b0; ts_valid = 1'b0; ts_instr = '0; ts_thread = '0; ts_sub = '0;
    rb_en = 1'b0; rb_t = '0; wb_en = 1'b0; wb_t = '0; wb_vec = 1'b0; wb_reg = '0;
    wb_val = '0; wb_mask = '0;
  endtask

  task automatic rand_val();
    for (int i = 0; i < L; i++) wb_val[i] = $urandom;
  endtask

  task automatic rand_instr();
    logic [95:0] raw;
    raw = {$urandom, $urandom, $urandom};
    ts_instr = raw[68:0];
  endtask

  initial begin
    vec_t exp_v;
    logic [31:0] prior;

    idle();
    reset = 1'b1;
    ts_valid = 1'b1;
    cycle();
    cycle();
    check("reset_op1", of_op1, '0);

    // Give every register a known value.
    for (int t = 0; t < T; t++) begin
      for (int r = 0; r < 32; r++) begin
        idle(); wb_en = 1'b1; wb_t = 2'(t); wb_reg = 5'(r); rand_val(); wb_mask = 16'h1234;
        cycle();
        idle(); wb_en = 1'b1; wb_vec = 1'b1; wb_t = 2'(t); wb_reg = 5'(r); rand_val(); wb_mask = '1;
        cycle();
      end
    end

    // Scalar write then broadcast read of both sources.
    idle(); wb_en = 1'b1; wb_t = 2'd2; wb_reg = 5'd5; rand_val(); wb_val[0] = 32'h12345678;
    wb_mask = 16'h0000;
    cycle();
    idle(); ts_valid = 1'b1; ts_thread = 2'd2; ts_sub = 4'd3;
    ts_instr.has_dest = 1'b1; ts_instr.dest_reg = 5'd1;
    ts_instr.scalar_sel1 = 5'd5; ts_instr.has_scalar2 = 1'b1; ts_instr.scalar_sel2 = 5'd5;
    ts_instr.is_masked = 1'b1;
    cycle();
    check("add_op1", of_op1, bcast(32'h12345678));
    check("add_op2", of_op2, bcast(32'h12345678));
    check("add_mask", VW'(of_mask), VW'(16'h5678));

    // Lane-masked vector write.
    idle(); wb_en = 1'b1; wb_vec = 1'b1; wb_reg = 5'd3; wb_mask = '1;
    for (int i = 0; i < L; i++) wb_val[i] = 32'(i);
    cycle();
    idle(); wb_en = 1'b1; wb_vec = 1'b1; wb_reg = 5'd3; wb_mask = 16'h00FF;
    wb_val = bcast(32'hFFFFFFFF);
    cycle();
    idle(); ts_valid = 1'b1; ts_instr.has_vector1 = 1'b1; ts_instr.vector_sel1 = 5'd3;
    cycle();
    for (int i = 0; i < L; i++) exp_v[i] = (i < 8) ? 32'hFFFFFFFF : 32'(i);
    check("vmask_op1", of_op1, exp_v);

    // Rollback squashes only the matching thread and leaves writes intact.
    idle(); ts_valid = 1'b1; ts_thread = 2'd1; rb_en = 1'b1; rb_t = 2'd1;
    wb_en = 1'b1; wb_t = 2'd1; wb_reg = 5'd9; wb_val[0] = 32'hCAFE0001;
    cycle();
    check("rollback_same", VW'(of_valid), VW'(1'b0));
    idle(); ts_valid = 1'b1; ts_thread = 2'd1; rb_en = 1'b1; rb_t = 2'd0;
    cycle();
    check("rollback_other", VW'(of_valid), VW'(1'b1));
    idle(); ts_valid = 1'b1; ts_thread = 2'd1; ts_instr.scalar_sel1 = 5'd9;
    cycle();
    check("rollback_write", of_op1, bcast(32'hCAFE0001));

    // Same-cycle write and read of s7.
    idle(); wb_en = 1'b1; wb_reg = 5'd7; wb_val[0] = 32'h00000001;
    cycle();
    idle(); wb_en = 1'b1; wb_reg = 5'd7; wb_val[0] = 32'h0000000A;
    ts_valid = 1'b1; ts_instr.scalar_sel1 = 5'd7;
    cycle();
`ifdef OF_WRITE_BYPASS_EN
    check("bypass_s7", of_op1, bcast(32'h0000000A));
`else
    check("bypass_s7", of_op1, bcast(32'h00000001));
`endif
    idle(); ts_valid = 1'b1; ts_instr.scalar_sel1 = 5'd7;
    cycle();
    check("after_s7", of_op1, bcast(32'h0000000A));

    // Thread isolation.
    prior = s_m[3][7];
    idle(); ts_valid = 1'b1; ts_thread = 2'd3; ts_instr.scalar_sel1 = 5'd7;
    cycle();
    check("isolation", of_op1, bcast(prior));

    // Reset mid-stream, then immediate operand.
    idle(); ts_valid = 1'b1; ts_thread = 2'd2; rand_instr();
    cycle();
    idle(); reset = 1'b1; ts_valid = 1'b1; rand_instr();
    cycle();
    check("midreset_valid", VW'(of_valid), VW'(1'b0));
    check("midreset_op2", of_op2, '0);
    idle();
    cycle();
    idle(); ts_valid = 1'b1; ts_instr.immediate_value = 32'h00000055;
    cycle();
    check("imm_op2", of_op2, bcast(32'h00000055));

    // Randomized traffic, biased toward same-cycle read/write conflicts.
    for (int n = 0; n < 400; n++) begin
      idle();
      reset = ($urandom_range(0, 49) == 0);
      ts_valid = 1'($urandom);
      rand_instr();
      ts_thread = 2'($urandom);
      ts_sub = 4'($urandom);
      rb_en = ($urandom_range(0, 3) == 0);
      rb_t = 2'($urandom);
      wb_en = 1'($urandom);
      wb_t = 2'($urandom);
      wb_vec = 1'($urandom);
      wb_reg = 5'($urandom);
      rand_val();
      wb_mask = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        wb_t = ts_thread;
        wb_reg = wb_vec ? ts_instr.vector_sel1 : ts_instr.scalar_sel2;
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter NUM_VECTOR_LANES, default 16, lanes per vector register.
REQ-002 SHALL have parameter THREADS_PER_CORE, default 4, hardware threads with private register files.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ts_instruction_valid  in  1  issued instruction present.
REQ-006 SHALL have port ts_instruction  in  decoded_instruction_t  issued instruction.
REQ-007 SHALL have port ts_thread_idx  in  thread_idx_t  issuing thread.
REQ-008 SHALL have port ts_subcycle  in  subcycle_t  issuing subcycle.
REQ-009 SHALL have ports wb_rollback_en (in, 1) and wb_rollback_thread_idx (in, thread_idx_t), the rollback request.
REQ-010 SHALL have ports wb_writeback_en (in, 1), wb_writeback_thread_idx (in, thread_idx_t), wb_writeback_is_vector (in, 1) and wb_writeback_reg (in, register_idx_t), the register write.
REQ-011 SHALL have ports wb_writeback_value (in, vector_t) and wb_writeback_mask (in, NUM_VECTOR_LANES), the write data and lane enables.
REQ-012 SHALL have ports of_instruction_valid (out, 1), of_instruction (out, decoded_instruction_t), of_thread_idx (out, thread_idx_t) and of_subcycle (out, subcycle_t), the registered copy of the issue.
REQ-013 SHALL have ports of_operand1 (out, vector_t), of_operand2 (out, vector_t) and of_mask_value (out, NUM_VECTOR_LANES), the fetched operands.

Function
REQ-014 SHALL hold, per thread, 32 scalar registers x 32 bits and 32 vector registers x NUM_VECTOR_LANES x 32 bits.
REQ-015 SHALL present outputs exactly 1 cycle after ts_* inputs; no stall or backpressure path exists.
REQ-016 of_operand1 SHALL be vector_sel1 register if has_vector1; otherwise scalar_sel1 value broadcast to all lanes.
REQ-017 of_operand2 SHALL be vector_sel2 register if has_vector2; else scalar_sel2 broadcast if has_scalar2; else immediate_value broadcast.
REQ-018 of_mask_value SHALL be the low NUM_VECTOR_LANES bits of the scalar_sel2 register when instruction is_masked; otherwise all ones.
REQ-019 of_instruction_valid SHALL be ts_instruction_valid delayed 1 cycle, forced 0 when wb_rollback_en and wb_rollback_thread_idx == ts_thread_idx in the input cycle.
REQ-020 A scalar write SHALL store lane 0 of wb_writeback_value, ignoring wb_writeback_mask.
REQ-021 A vector write SHALL update only lanes whose wb_writeback_mask bit is 1; other lanes keep their value.
REQ-022 Writes SHALL take effect at the clock edge ending the write cycle, with at most one write per cycle.
REQ-023 Rollback SHALL NOT block or alter a same-cycle write.
REQ-024 Operand data, instruction, thread and subcycle outputs SHALL be don't-care when of_instruction_valid is 0.

Reset
REQ-025 On reset, of_instruction_valid, of_instruction, of_thread_idx, of_subcycle, of_operand1, of_operand2 and of_mask_value SHALL be 0.
REQ-026 Register file contents SHALL NOT be reset; a read before first write returns an undefined value.
REQ-027 Reset asserted mid-stream SHALL discard the in-flight instruction; the first valid output is 1 cycle after the first valid input following reset deassertion.

Configuration
REQ-028 Macro OF_WRITE_BYPASS_EN SHALL control same-cycle write-to-read forwarding.
REQ-029 Macro defined: a read of the same thread, register and kind being written that cycle SHALL return the new value, merged lane-wise under wb_writeback_mask.
REQ-030 Macro undefined: that read SHALL return the pre-write value; correctness relies on the scoreboard never issuing such a read.

Verification
REQ-031 Write s5=0x12345678 on thread 2, then issue add s1,s5,s5 on thread 2 -> next cycle of_operand1 and of_operand2 are all lanes 0x12345678.
REQ-032 Write v3=lane i value i, then masked write v3=0xFFFFFFFF with mask 0x00FF -> read v3 gives lanes 0-7 = 0xFFFFFFFF and lanes 8-15 = i.
REQ-033 Issue valid on thread 1 with same-cycle rollback of thread 1 -> of_instruction_valid=0 next cycle; same case with rollback of thread 0 -> of_instruction_valid=1.
REQ-034 Same-cycle write s7=0xA and read s7 on thread 0 -> operand 0xA with OF_WRITE_BYPASS_EN, prior value without it.
REQ-035 Write s7=0xA on thread 0, then read s7 on thread 3 -> thread 3 value unchanged (thread isolation).
REQ-036 Assert reset while valid is in flight -> all outputs 0 next cycle; immediate_value=0x55 with no sources -> of_operand2 all lanes 0x55.
